mul_vector_seq: RTL and testbench

MUL_VECTOR_SEQ -- requirements
Module: mul_vector_seq

---
 rtl/mul_vector_seq.sv | 109 ++++++++++
 tb/tb_mul_vector_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_vector_seq.sv
// Bit-sliced vector multiplier: LANES independent WIDTH_N x WIDTH_N multiplies,
// one B bit-plane per clock, with optional accumulation onto the previous result.
module mul_vector_seq #(
    parameter int WIDTH_N = 2,
    parameter int LANES   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         accumulate,
    input  logic [WIDTH_N*LANES-1:0]     a,
    input  logic [WIDTH_N*LANES-1:0]     b,
    output logic [2*WIDTH_N*LANES-1:0]   y,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = WIDTH_N * LANES;
    localparam int YW = 2 * AW;
    localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   a_reg, b_reg;
    logic [YW-1:0]   acc_reg, acc_next, y_reg;
    logic [CW-1:0]   cnt_reg;
    logic [LANES-1:0] b_plane;
    logic            accept, last_plane;

    logic [LANES-1:0][WIDTH_N-1:0]   a_lane;
    logic [LANES-1:0][2*WIDTH_N-1:0] acc_lane, sum_lane;

    assign accept     = start && (state_reg != RUN);
    assign last_plane = (cnt_reg == LAST);

    always_comb begin
        b_plane = '0;
        for (int i = 0; i < WIDTH_N; i++) begin
            if (cnt_reg == CW'(i)) begin
                b_plane = b_reg[i*LANES +: LANES];
            end
        end
    end

    // Transpose bit-planes into per-lane words, add the shifted partial product,
    // and transpose the sum back; lanes never exchange carries.
    genvar gi, gj;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            for (gj = 0; gj < WIDTH_N; gj++) begin : g_a
                assign a_lane[gi][gj] = a_reg[gj*LANES + gi];
            end
            for (gj = 0; gj < 2*WIDTH_N; gj++) begin : g_acc
                assign acc_lane[gi][gj]         = acc_reg[gj*LANES + gi];
                assign acc_next[gj*LANES + gi]  = sum_lane[gi][gj];
            end
            assign sum_lane[gi] = acc_lane[gi] +
                (b_plane[gi] ? ({{WIDTH_N{1'b0}}, a_lane[gi]} << cnt_reg) : '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_plane) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            y_reg   <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            acc_reg <= accumulate ? y_reg : '0;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            acc_reg <= acc_next;
            // Only the final sum is published, so y never shows partial results.
            if (last_plane) begin
                y_reg <= acc_next;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign y    = y_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_mul_vector_seq.sv
// Bench for mul_vector_seq: a 2x16 and a 4x8 instance checked every cycle
// against a per-lane integer multiply model, plus literal expectations.
module tb_mul_vector_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [1:0]       start_i = '0;
    logic [1:0]       acc_i = '0;
    logic [1:0][31:0] a_i = '0;
    logic [1:0][31:0] b_i = '0;
    logic [1:0][63:0] y_o;
    logic [1:0]       busy_o, done_o;

    int errors = 0;
    int checks = 0;

    int          left_m [2];
    logic [63:0] y_m    [2];
    logic [63:0] res_m  [2];
    logic        done_m [2];

    always #5 clk = ~clk;

    mul_vector_seq #(.WIDTH_N(2), .LANES(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .accumulate(acc_i[0]),
        .a(a_i[0]), .b(b_i[0]), .y(y_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    mul_vector_seq #(.WIDTH_N(4), .LANES(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .accumulate(acc_i[1]),
        .a(a_i[1]), .b(b_i[1]), .y(y_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    function automatic int wid(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int lan(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic logic [63:0] model_mul(input int w, input int l,
                                              input logic [31:0] av, input logic [31:0] bv,
                                              input logic [63:0] yp, input logic acc);
        logic [63:0] r;
        int x, z, s, p;
        r = '0;
        for (int ln = 0; ln < l; ln++) begin
            x = 0; z = 0; s = 0;
            for (int i = 0; i < w; i++) begin
                x += int'(av[i*l + ln]) << i;
                z += int'(bv[i*l + ln]) << i;
            end
            for (int i = 0; i < 2*w; i++) s += int'(yp[i*l + ln]) << i;
            p = (x * z + (acc ? s : 0)) % (1 << (2*w));
            for (int i = 0; i < 2*w; i++) r[i*l + ln] = p[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timeline model: an accepted start yields its result W edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                left_m[k] <= 0;
                y_m[k]    <= '0;
                res_m[k]  <= '0;
                done_m[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                done_m[k] <= 1'b0;
                if (left_m[k] > 0) begin
                    left_m[k] <= left_m[k] - 1;
                    if (left_m[k] == 1) begin
                        y_m[k]    <= res_m[k];
                        done_m[k] <= 1'b1;
                    end
                end else if (start_i[k]) begin
                    res_m[k]  <= model_mul(wid(k), lan(k), a_i[k], b_i[k], y_m[k], acc_i[k]);
                    left_m[k] <= wid(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.busy", k), 64'(busy_o[k]), 64'(left_m[k] > 0));
                check($sformatf("u%0d.done", k), 64'(done_o[k]), 64'(done_m[k]));
                check($sformatf("u%0d.y", k), y_o[k], y_m[k]);
            end
        end
    end

    task automatic wait_done(input int k, inout int cyc);
        while (!done_o[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("u%0d.done_seen", k), 64'(done_o[k]), 64'd1);
    endtask

    task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic acc, output int cyc);
        @(negedge clk);
        a_i[k] = av; b_i[k] = bv; acc_i[k] = acc; start_i[k] = 1'b1;
        @(negedge clk);
        start_i[k] = 1'b0;
        a_i[k] = $urandom; b_i[k] = $urandom; acc_i[k] = 1'($urandom_range(0, 1));
        cyc = 1;
        wait_done(k, cyc);
        $display("op u%0d a=%h b=%h acc=%0d -> y=%h latency=%0d", k, av, bv, acc, y_o[k], cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_y", y_o[k], 64'd0);
            check("reset_busy", 64'(busy_o[k]), 64'd0);
            check("reset_done", 64'(done_o[k]), 64'd0);
        end
        rst_n = 1'b1;

        // 3*3 = 9 in every lane, then accumulate wraps to 18 mod 16 = 2
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
        check("all_ones_y", y_o[0], 64'hFFFF_0000_0000_FFFF);
        check("latency_w2", 64'(cyc), 64'd3);
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, cyc);
        check("acc_wrap_y", y_o[0], 64'h0000_0000_FFFF_0000);

        do_op(0, 32'h0001_0002, 32'h0001_0003, 1'b0, cyc);
        check("mixed_y", y_o[0], 64'h0000_0001_0001_0002);

        // start held through RUN and into DONE, operands changed after sampling
        @(negedge clk);
        a_i[0] = 32'h0001_0002; b_i[0] = 32'h0001_0003; acc_i[0] = 1'b0; start_i[0] = 1'b1;
        @(negedge clk);
        a_i[0] = 32'hFFFF_FFFF; b_i[0] = 32'hFFFF_FFFF;
        cyc = 1;
        wait_done(0, cyc);
        check("held_first_y", y_o[0], 64'h0000_0001_0001_0002);
        check("held_first_lat", 64'(cyc), 64'd3);
        @(negedge clk);
        start_i[0] = 1'b0;
        check("held_busy_b2b", 64'(busy_o[0]), 64'd1);
        cyc = 1;
        wait_done(0, cyc);
        check("held_second_y", y_o[0], 64'hFFFF_0000_0000_FFFF);
        check("held_second_lat", 64'(cyc), 64'd3);
        $display("op u0 held-start back-to-back -> y=%h", y_o[0]);

        // reset pulse inside the first RUN cycle
        @(negedge clk);
        a_i[0] = 32'h0001_0002; b_i[0] = 32'h0001_0003; acc_i[0] = 1'b0; start_i[0] = 1'b1;
        @(posedge clk);
        #2 start_i[0] = 1'b0; rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_o[0]), 64'd0);
        check("abort_done", 64'(done_o[0]), 64'd0);
        check("abort_y", y_o[0], 64'd0);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", 64'(done_o[0]), 64'd0);
        end
        do_op(0, 32'h0001_0002, 32'h0001_0003, 1'b0, cyc);
        check("after_abort_y", y_o[0], 64'h0000_0001_0001_0002);

        // 4x8: lane0 15*15 = 225, then accumulate 450 mod 256 = 194
        do_op(1, 32'h0101_0101, 32'h0101_0101, 1'b0, cyc);
        check("w4_lane0_y", y_o[1], 64'h0101_0100_0000_0001);
        check("latency_w4", 64'(cyc), 64'd5);
        do_op(1, 32'h0101_0101, 32'h0101_0101, 1'b1, cyc);
        check("w4_acc_y", y_o[1], 64'h0101_0000_0000_0100);

        for (int i = 0; i < 30; i++) begin
            do_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), cyc);
        end
        for (int i = 0; i < 10; i++) begin
            do_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)), cyc);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
